// File: rtl/mpc_types.sv
// rtl/mpc_types.sv - shared crossbar request types and channel count
package mpc_types;

   localparam int XBAR_NUM_CH = 3;

   typedef struct packed {
      logic [31:0] addr;
      logic [23:0] wdata;
      logic [7:0]  tag;
   } channel_req_t;

endpackage

// File: rtl/xbar_rr_pick.sv
// rtl/xbar_rr_pick.sv - combinational round-robin pick from a pointer
module xbar_rr_pick #(
   parameter int NUM_CH = 3,
   parameter int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [PTR_W-1:0]  rr_ptr,
   output logic [NUM_CH-1:0] gnt,
   output logic [PTR_W-1:0]  win_idx
);

   int   k;
   logic found;

   // Walk channels starting at rr_ptr, wrapping at NUM_CH; first requester wins.
   always_comb begin
      gnt     = '0;
      win_idx = '0;
      found   = 1'b0;
      k       = 0;
      for (int i = 0; i < NUM_CH; i++) begin
         k = int'(rr_ptr) + i;
         if (k >= NUM_CH) begin
            k = k - NUM_CH;
         end
         if (!found && req[k]) begin
            found   = 1'b1;
            gnt[k]  = 1'b1;
            win_idx = PTR_W'(k);
         end
      end
   end

endmodule

// File: rtl/xbar_bank_arb.sv
// rtl/xbar_bank_arb.sv - per-bank round-robin request arbiter with one-entry output stage
module xbar_bank_arb
   import mpc_types::*;
#(
   parameter int NUM_CH = XBAR_NUM_CH,
   parameter int DATA_W = 64,
   parameter int CNT_W  = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_CH-1:0]        u_req_valid,
   output logic [NUM_CH-1:0]        u_req_ready,
   input  logic [NUM_CH*DATA_W-1:0] u_req_data,
   output logic                     d_req_valid,
   input  logic                     d_req_ready,
   output logic [DATA_W-1:0]        d_req_data,
   output logic [NUM_CH-1:0]        d_ch_1hot_id,
   output logic [CNT_W-1:0]         conflict_cnt
);

   localparam int PTR_W = $clog2(NUM_CH);

   if (DATA_W != $bits(channel_req_t)) begin : g_width_chk
      $error("xbar_bank_arb: DATA_W must equal the width of channel_req_t");
   end

   logic [PTR_W-1:0]  rr_ptr;
   logic [NUM_CH-1:0] gnt;
   logic [PTR_W-1:0]  win_idx;
   logic [DATA_W-1:0] win_data;
   logic              load_en;
   logic              multi_req;

   xbar_rr_pick #(
      .NUM_CH (NUM_CH),
      .PTR_W  (PTR_W)
   ) u_pick (
      .req     (u_req_valid),
      .rr_ptr  (rr_ptr),
      .gnt     (gnt),
      .win_idx (win_idx)
   );

   assign load_en     = ~d_req_valid | d_req_ready;
   assign u_req_ready = (load_en && !rst) ? gnt : '0;
   assign multi_req   = ($countones(u_req_valid) > 1);

   always_comb begin
      win_data = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (gnt[i]) begin
            win_data = u_req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Stage reloads whenever it is empty or draining; stall freezes it and the pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         d_req_valid  <= 1'b0;
         d_req_data   <= '0;
         d_ch_1hot_id <= '0;
         rr_ptr       <= '0;
      end else if (load_en) begin
         if (|gnt) begin
            d_req_valid  <= 1'b1;
            d_req_data   <= win_data;
            d_ch_1hot_id <= gnt;
            rr_ptr       <= (win_idx == PTR_W'(NUM_CH - 1)) ? '0 : win_idx + 1'b1;
         end else begin
            d_req_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         conflict_cnt <= '0;
      end else if (multi_req && (conflict_cnt != {CNT_W{1'b1}})) begin
         conflict_cnt <= conflict_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_xbar_bank_arb.sv
// tb/tb_xbar_bank_arb.sv - directed table plus randomized reference-model bench for xbar_bank_arb
module tb_xbar_bank_arb;

   localparam int N  = 3;
   localparam int DW = 64;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      u_req_valid;
   logic [N*DW-1:0]   u_req_data;
   logic              d_req_ready;

   logic [N-1:0]      u_req_ready,  u_req_ready_s;
   logic              d_req_valid,  d_req_valid_s;
   logic [DW-1:0]     d_req_data,   d_req_data_s;
   logic [N-1:0]      d_ch_1hot_id, d_ch_1hot_id_s;
   logic [15:0]       conflict_cnt;
   logic [3:0]        conflict_cnt_s;

   always #5 clk = ~clk;

   xbar_bank_arb #(.NUM_CH(N), .DATA_W(DW), .CNT_W(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .u_req_valid  (u_req_valid),
      .u_req_ready  (u_req_ready),
      .u_req_data   (u_req_data),
      .d_req_valid  (d_req_valid),
      .d_req_ready  (d_req_ready),
      .d_req_data   (d_req_data),
      .d_ch_1hot_id (d_ch_1hot_id),
      .conflict_cnt (conflict_cnt)
   );

   xbar_bank_arb #(.NUM_CH(N), .DATA_W(DW), .CNT_W(4)) dut_small (
      .clk          (clk),
      .rst          (rst),
      .u_req_valid  (u_req_valid),
      .u_req_ready  (u_req_ready_s),
      .u_req_data   (u_req_data),
      .d_req_valid  (d_req_valid_s),
      .d_req_ready  (d_req_ready),
      .d_req_data   (d_req_data_s),
      .d_ch_1hot_id (d_ch_1hot_id_s),
      .conflict_cnt (conflict_cnt_s)
   );

   int n_cmp = 0;
   int n_bad = 0;

   bit          m_valid;
   logic [63:0] m_data;
   int          m_ch;
   int          m_ptr;
   int          m_cnt16;
   int          m_cnt4;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic int model_winner(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) begin
         if (v[(m_ptr + i) % N]) return (m_ptr + i) % N;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] onehot(input int ch);
      logic [N-1:0] r;
      r = '0;
      if (ch >= 0) r[ch] = 1'b1;
      return r;
   endfunction

   task automatic step(input logic r, input logic [N-1:0] v, input logic dr,
                       output logic [N-1:0] rdy_seen);
      int w;
      bit load;
      logic [N-1:0] er;
      rst = r;
      u_req_valid = v;
      d_req_ready = dr;
      #1;
      w = model_winner(v);
      load = !m_valid || dr;
      er = (!r && load) ? onehot(w) : '0;
      rdy_seen = u_req_ready;
      chk("u_req_ready", 64'(u_req_ready), 64'(er));
      chk("u_req_ready_small", 64'(u_req_ready_s), 64'(er));
      @(posedge clk);
      if (r) begin
         m_valid = 0; m_data = '0; m_ch = -1; m_ptr = 0; m_cnt16 = 0; m_cnt4 = 0;
      end else begin
         if (load) begin
            if (w >= 0) begin
               m_valid = 1;
               m_data  = u_req_data[w*DW +: DW];
               m_ch    = w;
               m_ptr   = (w + 1) % N;
            end else begin
               m_valid = 0;
            end
         end
         if ($countones(v) >= 2) begin
            if (m_cnt16 < 65535) m_cnt16++;
            if (m_cnt4 < 15) m_cnt4++;
         end
      end
      #1;
      chk("d_req_valid", 64'(d_req_valid), 64'(m_valid));
      chk("d_req_data", d_req_data, m_data);
      chk("d_ch_1hot_id", 64'(d_ch_1hot_id), 64'(onehot(m_ch)));
      chk("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt16));
      chk("conflict_cnt_small", 64'(conflict_cnt_s), 64'(m_cnt4));
   endtask

   typedef struct {
      logic       r;
      logic [2:0] v;
      logic       dr;
      logic [2:0] er;
      logic       edv;
      logic [2:0] eid;
      logic [7:0] edata;
      int         ecnt;
   } vec_t;

   vec_t tbl[21];

   initial begin
      logic [N-1:0] rdy;
      m_valid = 0; m_data = '0; m_ch = -1; m_ptr = 0; m_cnt16 = 0; m_cnt4 = 0;
      u_req_data = {64'hA5, 64'h22, 64'h11};

      tbl = '{
         '{1'b1, 3'b111, 1'b1, 3'b000, 1'b0, 3'b000, 8'h00, 0},
         '{1'b1, 3'b111, 1'b0, 3'b000, 1'b0, 3'b000, 8'h00, 0},
         '{1'b0, 3'b111, 1'b1, 3'b001, 1'b1, 3'b001, 8'h11, 1},
         '{1'b0, 3'b111, 1'b1, 3'b010, 1'b1, 3'b010, 8'h22, 2},
         '{1'b0, 3'b111, 1'b1, 3'b100, 1'b1, 3'b100, 8'hA5, 3},
         '{1'b0, 3'b111, 1'b1, 3'b001, 1'b1, 3'b001, 8'h11, 4},
         '{1'b0, 3'b100, 1'b1, 3'b100, 1'b1, 3'b100, 8'hA5, 4},
         '{1'b0, 3'b101, 1'b1, 3'b001, 1'b1, 3'b001, 8'h11, 5},
         '{1'b0, 3'b000, 1'b1, 3'b000, 1'b0, 3'b001, 8'h11, 5},
         '{1'b0, 3'b110, 1'b0, 3'b010, 1'b1, 3'b010, 8'h22, 6},
         '{1'b0, 3'b111, 1'b0, 3'b000, 1'b1, 3'b010, 8'h22, 7},
         '{1'b0, 3'b111, 1'b0, 3'b000, 1'b1, 3'b010, 8'h22, 8},
         '{1'b0, 3'b111, 1'b0, 3'b000, 1'b1, 3'b010, 8'h22, 9},
         '{1'b0, 3'b111, 1'b0, 3'b000, 1'b1, 3'b010, 8'h22, 10},
         '{1'b0, 3'b111, 1'b0, 3'b000, 1'b1, 3'b010, 8'h22, 11},
         '{1'b0, 3'b111, 1'b1, 3'b100, 1'b1, 3'b100, 8'hA5, 12},
         '{1'b0, 3'b011, 1'b1, 3'b001, 1'b1, 3'b001, 8'h11, 13},
         '{1'b0, 3'b011, 1'b0, 3'b000, 1'b1, 3'b001, 8'h11, 14},
         '{1'b1, 3'b011, 1'b0, 3'b000, 1'b0, 3'b000, 8'h00, 0},
         '{1'b0, 3'b111, 1'b1, 3'b001, 1'b1, 3'b001, 8'h11, 1},
         '{1'b0, 3'b000, 1'b1, 3'b000, 1'b0, 3'b001, 8'h11, 1}
      };

      for (int i = 0; i < 21; i++) begin
         step(tbl[i].r, tbl[i].v, tbl[i].dr, rdy);
         chk($sformatf("tbl%0d_ready", i), 64'(rdy), 64'(tbl[i].er));
         chk($sformatf("tbl%0d_dvalid", i), 64'(d_req_valid), 64'(tbl[i].edv));
         chk($sformatf("tbl%0d_id", i), 64'(d_ch_1hot_id), 64'(tbl[i].eid));
         chk($sformatf("tbl%0d_data", i), d_req_data, 64'(tbl[i].edata));
         chk($sformatf("tbl%0d_cnt", i), 64'(conflict_cnt), 64'(tbl[i].ecnt));
      end

      // Two requesters for 20 cycles: narrow counter must pin at 15, wide one keeps counting.
      for (int i = 0; i < 20; i++) step(1'b0, 3'b011, 1'b1, rdy);
      chk("sat_small_cnt", 64'(conflict_cnt_s), 64'd15);
      chk("wide_cnt", 64'(conflict_cnt), 64'd21);

      for (int i = 0; i < 1500; i++) begin
         logic r;
         logic dr;
         u_req_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         r  = ($urandom_range(0, 63) == 0);
         dr = ($urandom_range(0, 3) != 0);
         step(r, N'($urandom), dr, rdy);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
